hdmi_pixel_feeder: RTL and testbench

- Upstream neighbour of the HDMI timing generator. Runs in the pixel clock domain.
- Pops RGB565 pixels from the show-ahead (FWFT) SDRAM read FIFO on each data_req and expands them to RGB888 on pixel_data, one cycle after the request.
- Issues a per-frame read-restart pulse to the SDRAM read port, waits for FIFO prefill, substitutes a fill colour on underflow, and checks per-frame pixel count.

---
 rtl/hdmi_pixel_feeder_pkg.sv | 24 ++
 rtl/hdmi_pixel_feeder_if.sv | 25 ++
 rtl/hdmi_pixel_feeder_vs_edge_det.sv | 18 +
 rtl/hdmi_pixel_feeder.sv | 138 +++++++++++++
 tb/tb_hdmi_pixel_feeder.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdmi_pixel_feeder_pkg.sv
// Shared video definitions for the pixel-clock side of the HDMI path:
// default raster size, feeder state encoding and the RGB565 -> RGB888 expansion.
package hdmi_pixel_feeder_pkg;

    localparam int H_DISP_DEF = 1920;
    localparam int V_DISP_DEF = 1080;
    localparam int POP_CNT_W  = 22;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        RUN
    } feed_state_t;

    // Widen each colour channel by replicating its top bits into the new LSBs,
    // so full-scale 5/6-bit values map to full-scale 8-bit values.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] pix);
        return {pix[15:11], pix[15:13],
                pix[10:5],  pix[10:9],
                pix[4:0],   pix[4:2]};
    endfunction

endpackage

// File: rtl/hdmi_pixel_feeder_if.sv
// Bundle of the timing-generator, FIFO and status signals around the pixel feeder.
// The slave modport is the feeder itself; the master modport is its environment.
interface hdmi_pixel_feeder_if;
    logic        video_vs;
    logic        data_req;
    logic [15:0] fifo_rdata;
    logic        fifo_empty;
    logic [10:0] fifo_usedw;
    logic        fifo_rd_en;
    logic [23:0] pixel_data;
    logic        rd_load;
    logic        underflow;
    logic        frame_err;
    logic [15:0] underflow_cnt;

    modport master (
        output video_vs, data_req, fifo_rdata, fifo_empty, fifo_usedw,
        input  fifo_rd_en, pixel_data, rd_load, underflow, frame_err, underflow_cnt
    );

    modport slave (
        input  video_vs, data_req, fifo_rdata, fifo_empty, fifo_usedw,
        output fifo_rd_en, pixel_data, rd_load, underflow, frame_err, underflow_cnt
    );
endinterface

// File: rtl/hdmi_pixel_feeder_vs_edge_det.sv
// Falling-edge detector for the active-low vertical sync. The previous sync level
// is registered and compared with the live input, giving a one-cycle frame-start pulse.
module vs_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vs_n_i,
    output logic fs_o
);
    logic vs_q;

    // Remember last cycle's sync level; reset high so a low sync at release counts as an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) vs_q <= 1'b1;
        else       vs_q <= vs_n_i;
    end

    assign fs_o = vs_q & ~vs_n_i;
endmodule

// File: rtl/hdmi_pixel_feeder.sv
// Pixel feeder: restarts the SDRAM read stream each frame, waits for FIFO prefill,
// then pops RGB565 words on request and presents them as RGB888 one cycle later.
// Underflows are replaced by the fill colour and recorded; per-frame pop count is checked.
module hdmi_pixel_feeder
    import hdmi_pixel_feeder_pkg::*;
#(
    parameter int          H_DISP   = H_DISP_DEF,
    parameter int          V_DISP   = V_DISP_DEF,
    parameter int          PREFILL  = 256,
    parameter int          LOAD_LEN = 4,
    parameter logic [23:0] FILL_RGB = 24'h000000
) (
    input  logic                  pixel_clk_i,
    input  logic                  sys_rst_i,
    hdmi_pixel_feeder_if.slave    bus
);
    localparam int                   LCW          = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;
    localparam logic [LCW-1:0]       LOAD_LAST    = LCW'(LOAD_LEN - 1);
    localparam logic [POP_CNT_W-1:0] FRAME_PIXELS = POP_CNT_W'(H_DISP * V_DISP);
    localparam logic [11:0]          PREFILL_LVL  = 12'(PREFILL);

    feed_state_t           state_q, state_d;
    logic [LCW-1:0]        load_cnt_q, load_cnt_d;
    logic [POP_CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
    logic [23:0]           pixel_q, pixel_d;
    logic                  rd_load_q, rd_load_d;
    logic                  uf_q, uf_d;
    logic [15:0]           uf_cnt_q, uf_cnt_d;
    logic                  ferr_q, ferr_d;

    logic fs;
    logic running;
    logic serve;
    logic pop;
    logic uflow;

    vs_edge_det u_vs_edge (
        .clk_i  (pixel_clk_i),
        .rst_i  (sys_rst_i),
        .vs_n_i (bus.video_vs),
        .fs_o   (fs)
    );

    assign running = (state_q == RUN);
    assign serve   = bus.data_req & running;
    assign pop     = serve & ~bus.fifo_empty;
    assign uflow   = serve & bus.fifo_empty;

    // Frame sequencing: any frame start restarts the read stream, LOAD holds for a fixed length, FILL waits for prefill.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        case (state_q)
            IDLE: begin
                if (fs) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                end
            end
            LOAD: begin
                if (fs) begin
                    load_cnt_d = '0;
                end else if (load_cnt_q == LOAD_LAST) begin
                    state_d    = FILL;
                    load_cnt_d = '0;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            FILL: begin
                if (fs) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                end else if ({1'b0, bus.fifo_usedw} >= PREFILL_LVL) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fs) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                load_cnt_d = '0;
            end
        endcase
    end

    // Pixel path and bookkeeping: expand or substitute fill, track underflows and per-frame request count.
    always_comb begin
        pixel_d   = pop ? rgb565_to_888(bus.fifo_rdata) : FILL_RGB;
        rd_load_d = (state_d == LOAD);
        uf_d      = uf_q | uflow;
        uf_cnt_d  = uf_cnt_q;
        if (uflow && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 16'd1;
        end
        pop_cnt_d = pop_cnt_q;
        if (fs) begin
            pop_cnt_d = '0;
        end else if (serve) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
        end
        ferr_d = ferr_q | (fs & running & (pop_cnt_q != FRAME_PIXELS));
    end

    // All feeder state, cleared immediately by the asynchronous reset.
    always_ff @(posedge pixel_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            pop_cnt_q  <= '0;
            pixel_q    <= FILL_RGB;
            rd_load_q  <= 1'b0;
            uf_q       <= 1'b0;
            uf_cnt_q   <= '0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            pixel_q    <= pixel_d;
            rd_load_q  <= rd_load_d;
            uf_q       <= uf_d;
            uf_cnt_q   <= uf_cnt_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.fifo_rd_en    = pop;
    assign bus.pixel_data    = pixel_q;
    assign bus.rd_load       = rd_load_q;
    assign bus.underflow     = uf_q;
    assign bus.frame_err     = ferr_q;
    assign bus.underflow_cnt = uf_cnt_q;
endmodule

// File: tb/tb_hdmi_pixel_feeder.sv
// Self-checking bench for hdmi_pixel_feeder with a small 4x2 raster so frame
// counting is quick. Expected pixels are queued when a request is driven and
// compared when the registered output appears one cycle later.
module tb_hdmi_pixel_feeder;
    import hdmi_pixel_feeder_pkg::*;

    localparam logic [23:0] FILL = 24'h000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [23:0] sb_q[$];

    hdmi_pixel_feeder_if bus ();

    hdmi_pixel_feeder #(
        .H_DISP   (4),
        .V_DISP   (2),
        .PREFILL  (256),
        .LOAD_LEN (4),
        .FILL_RGB (FILL)
    ) dut (
        .pixel_clk_i (clk),
        .sys_rst_i   (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Independent reference for the colour expansion using shifts and ORs.
    function automatic logic [23:0] model_rgb(input logic [15:0] p);
        logic [7:0] r8, g8, b8;
        r8 = ({3'b000, p[15:11]} << 3) | ({3'b000, p[15:11]} >> 2);
        g8 = ({2'b00,  p[10:5]}  << 2) | ({2'b00,  p[10:5]}  >> 4);
        b8 = ({3'b000, p[4:0]}   << 3) | ({3'b000, p[4:0]}   >> 2);
        return {r8, g8, b8};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.video_vs   = 1'b1;
        bus.data_req   = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = 16'h0000;
        bus.fifo_usedw = 11'd0;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [10:0] lvl);
        @(negedge clk);
        bus.video_vs   = 1'b0;
        bus.fifo_usedw = lvl;
        @(negedge clk);
        bus.video_vs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.video_vs   = 1'b1;
        bus.data_req   = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.fifo_rdata = 16'hF800;
        bus.fifo_usedw = 11'd300;
        @(negedge clk);
        checks += 6;
        if (bus.pixel_data !== FILL) begin errors++; $display("[TB] FAIL reset_pixel got %h want %h", bus.pixel_data, FILL); end
        if (bus.rd_load !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_load got %b want 0", bus.rd_load); end
        if (bus.underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_underflow got %b want 0", bus.underflow); end
        if (bus.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got %b want 0", bus.frame_err); end
        if (bus.underflow_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL reset_uf_cnt got %h want 0000", bus.underflow_cnt); end
        if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got %b want 0", bus.fifo_rd_en); end
        rst = 1'b0;
        bus.data_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame_start();
        int hi;
        do_reset();
        bus.fifo_usedw = 11'd255;
        @(negedge clk);
        bus.video_vs = 1'b0;
        #1;
        checks++;
        if (bus.rd_load !== 1'b0) begin errors++; $display("[TB] FAIL load_before_edge got %b want 0", bus.rd_load); end
        @(negedge clk);
        bus.video_vs = 1'b1;
        checks++;
        if (bus.rd_load !== 1'b1) begin errors++; $display("[TB] FAIL load_start got %b want 1", bus.rd_load); end
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.rd_load === 1'b1) hi++;
            @(negedge clk);
        end
        checks++;
        if (hi != 4) begin errors++; $display("[TB] FAIL load_len got %0d want 4", hi); end
        bus.data_req   = 1'b1;
        bus.fifo_empty = 1'b0;
        bus.fifo_rdata = 16'h1234;
        #1;
        checks++;
        if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL fill_hold_255 got %b want 0", bus.fifo_rd_en); end
        bus.fifo_usedw = 11'd256;
        @(negedge clk);
        checks++;
        if (bus.fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL run_at_256 got %b want 1", bus.fifo_rd_en); end
        bus.data_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_expansion();
        logic [15:0] vals[8];
        logic [23:0] exp_px;
        vals[0] = 16'hF800; vals[1] = 16'h07E0; vals[2] = 16'h0841; vals[3] = 16'h001F;
        vals[4] = 16'hFFFF; vals[5] = 16'h0000;
        vals[6] = 16'($urandom); vals[7] = 16'($urandom);
        do_reset();
        start_frame(11'd300);
        bus.fifo_empty = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            if (sb_q.size() != 0) begin
                exp_px = sb_q.pop_front();
                checks++;
                if (bus.pixel_data !== exp_px) begin errors++; $display("[TB] FAIL expand_%0d got %h want %h", i - 1, bus.pixel_data, exp_px); end
            end
            bus.data_req   = 1'b1;
            bus.fifo_rdata = vals[i];
            sb_q.push_back(model_rgb(vals[i]));
            #1;
            checks++;
            if (bus.fifo_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL pop_strobe_%0d got %b want 1", i, bus.fifo_rd_en); end
        end
        @(negedge clk);
        bus.data_req = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++; $display("[TB] FAIL scoreboard_empty got 0 entries want 1");
        end else begin
            exp_px = sb_q.pop_front();
            if (bus.pixel_data !== exp_px) begin errors++; $display("[TB] FAIL expand_last got %h want %h", bus.pixel_data, exp_px); end
        end
        @(negedge clk);
        checks++;
        if (bus.pixel_data !== FILL) begin errors++; $display("[TB] FAIL idle_fill got %h want %h", bus.pixel_data, FILL); end
    endtask

    task automatic test_underflow();
        logic [23:0] exp_px;
        do_reset();
        start_frame(11'd300);
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = 16'hF800;
        bus.data_req   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(FILL);
            #1;
            checks++;
            if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL uf_no_pop_%0d got %b want 0", i, bus.fifo_rd_en); end
            @(negedge clk);
            exp_px = sb_q.pop_front();
            checks++;
            if (bus.pixel_data !== exp_px) begin errors++; $display("[TB] FAIL uf_pixel_%0d got %h want %h", i, bus.pixel_data, exp_px); end
        end
        bus.data_req = 1'b0;
        checks += 2;
        if (bus.underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_flag got %b want 1", bus.underflow); end
        if (bus.underflow_cnt !== 16'd3) begin errors++; $display("[TB] FAIL uf_cnt3 got %h want 0003", bus.underflow_cnt); end
        bus.data_req = 1'b1;
        repeat (65531) @(negedge clk);
        bus.data_req = 1'b0;
        checks++;
        if (bus.underflow_cnt !== 16'hFFFE) begin errors++; $display("[TB] FAIL uf_cnt_fffe got %h want fffe", bus.underflow_cnt); end
        bus.data_req = 1'b1;
        repeat (3) @(negedge clk);
        bus.data_req = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.underflow_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL uf_cnt_sat got %h want ffff", bus.underflow_cnt); end
        if (bus.underflow !== 1'b1) begin errors++; $display("[TB] FAIL uf_sticky got %b want 1", bus.underflow); end
    endtask

    task automatic test_outside_run();
        logic [23:0] exp_px;
        do_reset();
        start_frame(11'd0);
        bus.fifo_empty = 1'b0;
        bus.fifo_rdata = 16'hF800;
        bus.data_req   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(FILL);
            #1;
            checks++;
            if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_pop_%0d got %b want 0", i, bus.fifo_rd_en); end
            @(negedge clk);
            exp_px = sb_q.pop_front();
            checks++;
            if (bus.pixel_data !== exp_px) begin errors++; $display("[TB] FAIL fill_pixel_%0d got %h want %h", i, bus.pixel_data, exp_px); end
        end
        bus.data_req   = 1'b0;
        bus.fifo_usedw = 11'd256;
        @(negedge clk);
        bus.data_req = 1'b1;
        repeat (8) @(negedge clk);
        bus.data_req = 1'b0;
        start_frame(11'd256);
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL fill_req_not_counted got %b want 0", bus.frame_err); end
    endtask

    task automatic test_frame_count();
        do_reset();
        start_frame(11'd300);
        for (int i = 0; i < 8; i++) begin
            bus.fifo_empty = (i % 3 == 1);
            bus.fifo_rdata = 16'($urandom);
            bus.data_req   = 1'b1;
            @(negedge clk);
        end
        bus.data_req = 1'b0;
        start_frame(11'd300);
        checks++;
        if (bus.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL count_good got %b want 0", bus.frame_err); end
        bus.fifo_empty = 1'b0;
        bus.data_req   = 1'b1;
        repeat (7) @(negedge clk);
        bus.data_req = 1'b0;
        start_frame(11'd300);
        checks++;
        if (bus.frame_err !== 1'b1) begin errors++; $display("[TB] FAIL count_short got %b want 1", bus.frame_err); end
        bus.data_req = 1'b1;
        repeat (8) @(negedge clk);
        bus.data_req = 1'b0;
        start_frame(11'd300);
        checks++;
        if (bus.frame_err !== 1'b1) begin errors++; $display("[TB] FAIL count_sticky got %b want 1", bus.frame_err); end
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        do_reset();
        start_frame(11'd300);
        bus.fifo_empty = 1'b1;
        bus.data_req   = 1'b1;
        repeat (2) @(negedge clk);
        bus.data_req = 1'b0;
        start_frame(11'd300);
        bus.fifo_empty = 1'b0;
        bus.fifo_rdata = 16'hF800;
        bus.data_req   = 1'b1;
        @(negedge clk);
        checks += 2;
        if (bus.pixel_data !== 24'hFF0000) begin errors++; $display("[TB] FAIL pre_reset_pixel got %h want ff0000", bus.pixel_data); end
        if (bus.frame_err !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_ferr got %b want 1", bus.frame_err); end
        rst = 1'b1;
        #1;
        checks += 6;
        if (bus.pixel_data !== FILL) begin errors++; $display("[TB] FAIL mid_rst_pixel got %h want %h", bus.pixel_data, FILL); end
        if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_rd_en got %b want 0", bus.fifo_rd_en); end
        if (bus.rd_load !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_rd_load got %b want 0", bus.rd_load); end
        if (bus.underflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_underflow got %b want 0", bus.underflow); end
        if (bus.frame_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_frame_err got %b want 0", bus.frame_err); end
        if (bus.underflow_cnt !== 16'h0000) begin errors++; $display("[TB] FAIL mid_rst_uf_cnt got %h want 0000", bus.underflow_cnt); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rd_load === 1'b1) seen = 1'b1;
            if (bus.fifo_rd_en === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_quiet got %b want 0", seen); end
        bus.data_req = 1'b0;
        bus.video_vs = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.video_vs = 1'b1;
            if (bus.rd_load === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_load got %b want 1", seen); end
    endtask

    initial begin
        bus.video_vs   = 1'b1;
        bus.data_req   = 1'b0;
        bus.fifo_rdata = 16'h0000;
        bus.fifo_empty = 1'b1;
        bus.fifo_usedw = 11'd0;
        test_reset();
        test_frame_start();
        test_expansion();
        test_underflow();
        test_outside_run();
        test_frame_count();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
